// File: rtl/div_sequencer.sv
// Multicycle signed divide controller: edge-case screening plus radix-2 restoring loop.
// Optional remainder output enabled by defining DIV_REMAINDER_EN.
module div_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
`ifdef DIV_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] data_remainder
`endif
);

    typedef enum logic [1:0] {StIdle, StScreen, StRun, StFix} state_e;

    localparam logic [WIDTH-1:0] MinVal   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] FastQ    = {2'b11, {(WIDTH-2){1'b0}}};
    localparam logic [WIDTH-1:0] One      = WIDTH'(1);
    localparam logic [WIDTH-1:0] Two      = WIDTH'(2);
    localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + One) : v;
    endfunction

    state_e           state_q, state_d;
    logic             sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic [WIDTH-1:0] q_q, q_d;   // holds |A| until RUN shifts it out, then the quotient
    logic [WIDTH-1:0] r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
`ifdef DIV_REMAINDER_EN
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] rem_q, rem_d;
`endif

    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] diff;
    logic           a_is_min;

    // R stays below |B| <= 2^(WIDTH-1), so r_shift[WIDTH] is zero and diff[WIDTH] is the borrow
    assign r_shift  = {r_q, q_q[WIDTH-1]};
    assign diff     = r_shift - {1'b0, mag_b_q};
    assign a_is_min = sa_q && (q_q == MinVal);

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        mag_b_d  = mag_b_q;
        q_d      = q_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
`ifdef DIV_REMAINDER_EN
        a_d      = a_q;
        rem_d    = rem_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (ctrl_div) begin
                    sa_d    = data_operandA[WIDTH-1];
                    sb_d    = data_operandB[WIDTH-1];
                    q_d     = magnitude(data_operandA);
                    mag_b_d = magnitude(data_operandB);
`ifdef DIV_REMAINDER_EN
                    a_d     = data_operandA;
`endif
                    state_d = StScreen;
                end
            end
            StScreen: begin
                rdy_d   = 1'b1;
                state_d = StIdle;
                if (mag_b_q == '0) begin
                    result_d = '0;
                    exc_d    = 1'b1;
`ifdef DIV_REMAINDER_EN
                    rem_d    = a_q;
`endif
                end else if (a_is_min && sb_q && mag_b_q == One) begin
                    result_d = MinVal;
                    exc_d    = 1'b1;
`ifdef DIV_REMAINDER_EN
                    rem_d    = '0;
`endif
                end else if (a_is_min && !sb_q && mag_b_q == Two) begin
                    result_d = FastQ;
                    exc_d    = 1'b0;
`ifdef DIV_REMAINDER_EN
                    rem_d    = '0;
`endif
                end else if (q_q < mag_b_q) begin
                    result_d = '0;
                    exc_d    = 1'b0;
`ifdef DIV_REMAINDER_EN
                    rem_d    = a_q;
`endif
                end else begin
                    rdy_d   = 1'b0;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!diff[WIDTH]) begin
                    r_d = diff[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = r_shift[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIter) state_d = StFix;
            end
            StFix: begin
                result_d = (sa_q ^ sb_q) ? (~q_q + One) : q_q;
                exc_d    = 1'b0;
                rdy_d    = 1'b1;
`ifdef DIV_REMAINDER_EN
                rem_d    = sa_q ? (~r_q + One) : r_q;
`endif
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            mag_b_q  <= '0;
            q_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
`ifdef DIV_REMAINDER_EN
            a_q      <= '0;
            rem_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            mag_b_q  <= mag_b_d;
            q_q      <= q_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
`ifdef DIV_REMAINDER_EN
            a_q      <= a_d;
            rem_q    <= rem_d;
`endif
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    // The ready cycle is already IDLE but still counts as busy
    assign busy           = (state_q != StIdle) || rdy_q;
`ifdef DIV_REMAINDER_EN
    assign data_remainder = rem_q;
`endif

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: driver pushes expected results, monitor pops on ready.
module tb_div_sequencer;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         ctrl_div = 1'b0;
    logic [W-1:0] data_operandA = '0;
    logic [W-1:0] data_operandB = '0;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;
`ifdef DIV_REMAINDER_EN
    logic [W-1:0] data_remainder;
`endif

    div_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_div       (ctrl_div),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
`ifdef DIV_REMAINDER_EN
        ,
        .data_remainder (data_remainder)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] res;
        logic         exc;
        logic [W-1:0] rem;
        int           lat;
        int           start;
        string        name;
    } exp_t;

    exp_t queue_exp[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) begin
                if (queue_exp.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = queue_exp.pop_front();
                    check({e.name, "_result"}, data_result, e.res);
                    check({e.name, "_exception"}, {31'd0, data_exception}, {31'd0, e.exc});
                    check({e.name, "_latency"}, cyc - e.start, e.lat);
`ifdef DIV_REMAINDER_EN
                    check({e.name, "_remainder"}, data_remainder, e.rem);
`endif
                end
            end
        end
    end

    // Called at a negedge: start edge is the next posedge
    task automatic start_now(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] res, input logic exc, input logic [W-1:0] rem,
                             input int lat, input bit expect_it);
        exp_t e;
        ctrl_div      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_div      = 1'b0;
        data_operandA = 'x;
        data_operandB = 'x;
        if (expect_it) begin
            e.res = res; e.exc = exc; e.rem = rem; e.lat = lat; e.start = cyc; e.name = name;
            queue_exp.push_back(e);
            check({name, "_busy"}, {31'd0, busy}, 32'd1);
        end
    endtask

    task automatic start_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] res, input logic exc, input logic [W-1:0] rem,
                             input int lat);
        @(negedge clock);
        start_now(name, a, b, res, exc, rem, lat, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (queue_exp.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (queue_exp.size() != 0) check("drain_timeout", 32'd1, 32'd0);
        @(negedge clock);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        check("rst_result", data_result, 32'd0);
        check("rst_exception", {31'd0, data_exception}, 32'd0);
        check("rst_ready", {31'd0, data_resultRDY}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        // Abort: reset at E10 of a 100/7 run, no ready must follow
        @(negedge clock);
        start_now("abort", 32'd100, 32'd7, 32'd0, 1'b0, 32'd0, 0, 1'b0);
        repeat (9) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_result", data_result, 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clock);

        start_div("d100_7", 32'd100, 32'd7, 32'd14, 1'b0, 32'd2, 34);
        drain();
        start_div("dm100_7", -32'sd100, 32'd7, 32'hFFFF_FFF2, 1'b0, 32'hFFFF_FFFE, 34);
        drain();
        start_div("d7_m100", 32'd7, -32'sd100, 32'd0, 1'b0, 32'd7, 1);
        drain();
        start_div("d5_0", 32'd5, 32'd0, 32'd0, 1'b1, 32'd5, 1);
        drain();
        start_div("dmin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'd0, 1);
        drain();
        start_div("dmin_2", 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0, 32'd0, 1);
        drain();
        start_div("dmin_3", 32'h8000_0000, 32'd3, 32'hD555_5556, 1'b0, 32'hFFFF_FFFE, 34);
        drain();
        start_div("dm21_m4", -32'sd21, -32'sd4, 32'd5, 1'b0, 32'hFFFF_FFFF, 34);
        drain();

        // Ignored start while busy, then a restart in the ready cycle
        start_div("d50_5", 32'd50, 32'd5, 32'd10, 1'b0, 32'd0, 34);
        repeat (3) @(posedge clock);
        @(negedge clock);
        start_now("ignored", 32'd9, 32'd3, 32'd0, 1'b0, 32'd0, 0, 1'b0);
        begin
            int n = 0;
            while (data_resultRDY !== 1'b1 && n < 100) begin
                @(negedge clock);
                n++;
            end
            if (data_resultRDY !== 1'b1) check("ready_timeout", 32'd1, 32'd0);
        end
        start_now("d9_3", 32'd9, 32'd3, 32'd3, 1'b0, 32'd0, 34, 1'b1);
        drain();

        repeat (5) @(negedge clock);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
